// File: rtl/cpu_mem_responder.sv
// Memory-side responder: 1K x 16 RAM, streaming program loader, and a small MMIO window.
// Define MEM_PROT_EN to block RUN-state CPU writes below PROT_LIMIT.
module cpu_mem_responder #(
   parameter int unsigned MEM_WORDS  = 1024,
   parameter logic [15:0] IO_BASE    = 16'hFFF0,
   parameter logic [15:0] PROT_LIMIT = 16'd256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic        write_en,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        cpu_hold,
   input  logic        ld_start,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [15:0] ld_data,
   input  logic        ld_last,
   output logic        ld_done,
   input  logic [15:0] game_in,
   output logic [15:0] led_reg,
   output logic        bus_err
);
   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = AW + 1;
   localparam logic [AW-1:0] CLR_LAST = AW'(MEM_WORDS - 1);
   localparam logic [PW-1:0] PTR_MAX  = PW'(MEM_WORDS);
`ifdef MEM_PROT_EN
   localparam bit PROT_ON = 1'b1;
`else
   localparam bit PROT_ON = 1'b0;
`endif

   typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;
   state_t state, state_nxt;

   logic [15:0]   ram [MEM_WORDS];
   logic [AW-1:0] clr_cnt;
   logic [PW-1:0] ld_ptr;
   logic [15:0]   cyc_cnt;

   logic          beat_ok, ptr_full, bus_live, restart;
   logic          in_ram, in_io, wr_prot;
   logic [15:0]   io_off, bus_rd;
   logic          ram_we;
   logic [AW-1:0] ram_wa;
   logic [15:0]   ram_wd;

   // ld_start wins over a same-cycle load beat and over the CPU bus
   assign restart  = ld_start && (state != ST_CLEAR);
   assign beat_ok  = (state == ST_LOAD) && ld_valid && !ld_start;
   assign ptr_full = (ld_ptr >= PTR_MAX);
   assign bus_live = (state == ST_RUN) && !ld_start;
   assign in_ram   = ({16'd0, addr} < MEM_WORDS);
   assign io_off   = addr - IO_BASE;
   assign in_io    = (addr >= IO_BASE) && (io_off < 16'd16);
   assign wr_prot  = PROT_ON && (addr < PROT_LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_ready  = 1'b0;
      cpu_hold  = 1'b1;
      case (state)
         ST_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = ST_LOAD;
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_start)                state_nxt = ST_CLEAR;
            else if (beat_ok && ld_last) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            cpu_hold = 1'b0;
            if (ld_start) state_nxt = ST_CLEAR;
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      ram_we = 1'b0;
      ram_wa = '0;
      ram_wd = '0;
      case (state)
         ST_CLEAR: begin
            ram_we = 1'b1;
            ram_wa = clr_cnt;
         end
         ST_LOAD: if (beat_ok && !ptr_full) begin
            ram_we = 1'b1;
            ram_wa = ld_ptr[AW-1:0];
            ram_wd = ld_data;
         end
         ST_RUN: if (bus_live && write_en && in_ram && !wr_prot) begin
            ram_we = 1'b1;
            ram_wa = addr[AW-1:0];
            ram_wd = data_in;
         end
         default: ram_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_wa] <= ram_wd;
   end

   // A blocked protected write returns the untouched RAM word
   always_comb begin
      bus_rd = '0;
      if (bus_live) begin
         if (in_ram) begin
            if (write_en && !wr_prot) bus_rd = data_in;
            else                      bus_rd = ram[addr[AW-1:0]];
         end else if (in_io) begin
            case (io_off[3:0])
               4'd0:    bus_rd = write_en ? 16'h0000 : game_in;
               4'd1:    bus_rd = write_en ? data_in : led_reg;
               4'd2:    bus_rd = write_en ? 16'h0000 : cyc_cnt;
               default: bus_rd = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_cnt  <= '0;
         ld_ptr   <= '0;
         cyc_cnt  <= '0;
         data_out <= '0;
         led_reg  <= '0;
         bus_err  <= 1'b0;
         ld_done  <= 1'b0;
      end else begin
         ld_done  <= beat_ok && ld_last;
         data_out <= bus_rd;
         if (restart) begin
            clr_cnt <= '0;
            ld_ptr  <= '0;
            cyc_cnt <= '0;
         end else begin
            if (state == ST_CLEAR)
               clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + AW'(1);
            if (beat_ok && !ptr_full)
               ld_ptr <= ld_ptr + PW'(1);
            if (state == ST_RUN)
               cyc_cnt <= cyc_cnt + 16'd1;
         end
         if (beat_ok && ptr_full)
            bus_err <= 1'b1;
         if (bus_live && ((!in_ram && !in_io) || (write_en && in_ram && wr_prot)))
            bus_err <= 1'b1;
         if (bus_live && in_io && (io_off[3:0] == 4'd1) && write_en)
            led_reg <= data_in;
      end
   end
endmodule
